// File: rtl/logic_analyzer_readout.sv
// Streams a completed capture out of the sample BRAM, oldest sample first, over valid/ready.
// Define LOGIC_ANALYZER_READOUT_INDEX_EN to add the m_index output.
module logic_analyzer_readout #(
  parameter int unsigned SAMPLE_DEPTH = 8,
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned READ_LATENCY = 2,
  localparam int unsigned ADDR_WIDTH = (SAMPLE_DEPTH > 1) ? $clog2(SAMPLE_DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    request_read,
  input  logic                    request_abort,
  input  logic [ADDR_WIDTH-1:0]   base_ptr,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic                    bram_en,
  input  logic [SAMPLE_WIDTH-1:0] bram_dout,
  output logic [SAMPLE_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
`ifdef LOGIC_ANALYZER_READOUT_INDEX_EN
  output logic [ADDR_WIDTH-1:0]   m_index,
`endif
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned FIFO_DEPTH = READ_LATENCY + 1;
  localparam int unsigned FPW = $clog2(FIFO_DEPTH);
  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CW  = $clog2(SAMPLE_DEPTH + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                  state_q;
  logic                    read_prev_q, abort_prev_q;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic [CW-1:0]           issued_q, accepted_q;
  logic                    busy_q, done_q;
  logic [READ_LATENCY-1:0] ret_valid_q;
  logic [SAMPLE_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [FPW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [FCW-1:0]          fifo_count_q;

  logic        read_rise, abort_rise, push, pop, last_accept;
  int unsigned inflight;

  function automatic logic [FPW-1:0] fifo_inc(input logic [FPW-1:0] p);
    return (p == FPW'(FIFO_DEPTH - 1)) ? '0 : p + FPW'(1);
  endfunction

  assign read_rise   = request_read & ~read_prev_q;
  assign abort_rise  = request_abort & ~abort_prev_q;
  assign m_valid     = (fifo_count_q != '0);
  assign m_data      = fifo_mem_q[rd_ptr_q];
  assign pop         = m_valid & m_ready;
  assign push        = ret_valid_q[READ_LATENCY-1];
  // The head is always the next sample to be accepted, so its index is the accept count.
  assign m_last      = m_valid && (32'(accepted_q) == SAMPLE_DEPTH - 1);
  assign last_accept = pop && (32'(accepted_q) == SAMPLE_DEPTH - 1);
  assign bram_addr   = ptr_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef LOGIC_ANALYZER_READOUT_INDEX_EN
  assign m_index = m_valid ? accepted_q[ADDR_WIDTH-1:0] : '0;
`endif

  // Credit check counts the slot freed by a same-cycle pop so the stream sustains 1 word/cycle.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < int'(READ_LATENCY); i++) begin
      inflight += 32'(ret_valid_q[i]);
    end
    bram_en = (state_q == StRun) && (32'(issued_q) < SAMPLE_DEPTH) &&
              (inflight + 32'(fifo_count_q) < FIFO_DEPTH + 32'(pop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      read_prev_q  <= 1'b0;
      abort_prev_q <= 1'b0;
      ptr_q        <= '0;
      issued_q     <= '0;
      accepted_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ret_valid_q  <= '0;
    end else begin
      read_prev_q  <= request_read;
      abort_prev_q <= request_abort;
      done_q       <= 1'b0;
      if (bram_en) begin
        issued_q <= issued_q + CW'(1);
        ptr_q    <= (ptr_q == ADDR_WIDTH'(SAMPLE_DEPTH - 1)) ? '0 : ptr_q + ADDR_WIDTH'(1);
      end
      if (pop) begin
        accepted_q <= accepted_q + CW'(1);
      end
      ret_valid_q[0] <= bram_en;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        ret_valid_q[i] <= ret_valid_q[i-1];
      end
      if (abort_rise) begin
        // Clearing the return tags drops every read still in the BRAM pipeline.
        state_q     <= StIdle;
        busy_q      <= 1'b0;
        ret_valid_q <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (read_rise) begin
              state_q    <= StRun;
              busy_q     <= 1'b1;
              ptr_q      <= base_ptr;
              issued_q   <= '0;
              accepted_q <= '0;
            end
          end
          StRun: begin
            if (last_accept) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else if (abort_rise) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= bram_dout;
        wr_ptr_q             <= fifo_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= fifo_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + FCW'(1);
        2'b01:   fifo_count_q <= fifo_count_q - FCW'(1);
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_analyzer_readout.sv
// Scoreboard bench for logic_analyzer_readout: stimulus queues expectations, a monitor checks them.
module tb_logic_analyzer_readout;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned RL    = 2;
  localparam int unsigned FD    = RL + 1;

  logic       clk = 1'b0;
  logic       rst_n, request_read, request_abort;
  logic [2:0] base_ptr, bram_addr;
  logic       bram_en, m_valid, m_last, busy, done;
  logic       m_ready = 1'b1;
  logic [7:0] bram_dout, m_data;
`ifdef LOGIC_ANALYZER_READOUT_INDEX_EN
  logic [2:0] m_index;
`endif

  always #5 clk = ~clk;

  logic_analyzer_readout #(
    .SAMPLE_DEPTH(DEPTH),
    .SAMPLE_WIDTH(8),
    .READ_LATENCY(RL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .request_read (request_read),
    .request_abort(request_abort),
    .base_ptr     (base_ptr),
    .bram_addr    (bram_addr),
    .bram_en      (bram_en),
    .bram_dout    (bram_dout),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
`ifdef LOGIC_ANALYZER_READOUT_INDEX_EN
    .m_index      (m_index),
`endif
    .busy         (busy),
    .done         (done)
  );

  // BRAM model: READ_LATENCY registered stages after the enable.
  logic [7:0] mem  [DEPTH];
  logic [7:0] pipe [RL];
  assign bram_dout = pipe[RL-1];
  always @(posedge clk) begin
    if (bram_en) pipe[0] <= mem[bram_addr];
    for (int i = 1; i < int'(RL); i++) pipe[i] <= pipe[i-1];
  end

  // Ready driver: constant 1, or the repeating 1,0,0,1 pattern.
  logic ready_mode = 1'b0;
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int   pcnt = 0;
  always @(posedge clk) begin
    #1;
    m_ready = ready_mode ? pat[pcnt % 4] : 1'b1;
    pcnt++;
  end

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [2:0] idx;
  } exp_t;

  exp_t       sb_q [$];
  logic [2:0] addr_q [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int xfer_count = 0;
  int first_xfer = -1;
  int last_xfer = -1;
  int outstanding = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard.
  logic       prev_stall = 1'b0;
  logic       prev_last_xfer = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    exp_t       e;
    logic [2:0] ea;
    if (prev_stall) begin
      chk("stall_valid_hold", 32'(m_valid), 32'd1);
      chk("stall_data_hold", 32'(m_data), 32'(prev_data));
    end
    if (prev_last_xfer || done) chk("done_pulse", 32'(done), 32'(prev_last_xfer));
    if (bram_en) begin
      if (addr_q.size() == 0) chk("unexpected_read_addr", 32'(bram_addr), 32'hffff);
      else begin
        ea = addr_q.pop_front();
        chk("bram_addr", 32'(bram_addr), 32'(ea));
      end
    end
    if (m_valid && m_ready) begin
      if (sb_q.size() == 0) chk("unexpected_sample", 32'(m_data), 32'hffff);
      else begin
        e = sb_q.pop_front();
        chk("m_data", 32'(m_data), 32'(e.data));
        chk("m_last", 32'(m_last), 32'(e.last));
`ifdef LOGIC_ANALYZER_READOUT_INDEX_EN
        chk("m_index", 32'(m_index), 32'(e.idx));
`endif
      end
      xfer_count++;
      if (first_xfer < 0) first_xfer = cyc;
      last_xfer = cyc;
    end
    outstanding = outstanding + (bram_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
    if (outstanding > int'(FD)) chk("fifo_overflow", 32'(outstanding), 32'(FD));
    prev_stall     = m_valid && !m_ready;
    prev_data      = m_data;
    prev_last_xfer = m_valid && m_ready && m_last;
    cyc++;
  end

  task automatic push_run(input int base);
    exp_t e;
    for (int i = 0; i < int'(DEPTH); i++) begin
      int a = (base + i) % int'(DEPTH);
      e.data = mem[a];
      e.last = (i == int'(DEPTH) - 1);
      e.idx  = 3'(i);
      sb_q.push_back(e);
      addr_q.push_back(3'(a));
    end
    xfer_count = 0;
    first_xfer = -1;
    last_xfer  = -1;
  endtask

  // Caller is at posedge+1; returns one posedge later, just after the start edge is captured.
  task automatic start_read(input int base);
    base_ptr     = 3'(base);
    request_read = 1'b1;
    @(posedge clk);
    #1 request_read = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      if (done) break;
      n++;
    end
    chk({name, "_done_seen"}, 32'(done), 32'd1);
    chk({name, "_busy_clear"}, 32'(busy), 32'd0);
    chk({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    chk({name, "_count"}, 32'(xfer_count), 32'(DEPTH));
  endtask

  task automatic flush_sb();
    sb_q.delete();
    addr_q.delete();
    outstanding = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 8'(i);
    rst_n = 1'b0; request_read = 1'b0; request_abort = 1'b0; base_ptr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_bram_en", 32'(bram_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Base 0, full-rate stream, latency check.
    push_run(0);
    start_read(0);
    chk("a_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 chk("a_lat1_valid", 32'(m_valid), 32'd0);
    @(posedge clk); #1 chk("a_lat2_valid", 32'(m_valid), 32'd0);
    @(posedge clk); #1 chk("a_lat3_valid", 32'(m_valid), 32'd1);
    chk("a_first_data", 32'(m_data), 32'd0);
    wait_done("a");
    chk("a_consecutive", 32'(last_xfer - first_xfer), 32'(DEPTH - 1));

    // Base 5 wraps: 5,6,7,0..4.
    push_run(5);
    start_read(5);
    wait_done("b");

    // Base 2 with backpressure and a start request while busy.
    ready_mode = 1'b1;
    push_run(2);
    start_read(2);
    repeat (4) @(posedge clk);
    #1 request_read = 1'b1;
    @(posedge clk);
    #1 request_read = 1'b0;
    wait_done("c");
    ready_mode = 1'b0;

    // Abort mid-readout, then immediate restart with new memory contents.
    push_run(0);
    start_read(0);
    n = 0;
    while (xfer_count < 3 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("d_reached_3", 32'(xfer_count >= 3), 32'd1);
    request_abort = 1'b1;
    @(posedge clk); #1;
    chk("d_abort_valid", 32'(m_valid), 32'd0);
    chk("d_abort_busy", 32'(busy), 32'd0);
    chk("d_abort_done", 32'(done), 32'd0);
    flush_sb();
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 8'h40 | 8'(i);
    request_abort = 1'b0;
    push_run(0);
    start_read(0);
    wait_done("d");

    // Asynchronous reset mid-readout.
    push_run(0);
    start_read(0);
    n = 0;
    while (xfer_count < 2 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("e_rst_valid", 32'(m_valid), 32'd0);
    chk("e_rst_en", 32'(bram_en), 32'd0);
    chk("e_rst_busy", 32'(busy), 32'd0);
    chk("e_rst_data", 32'(m_data), 32'd0);
    chk("e_rst_last", 32'(m_last), 32'd0);
    chk("e_rst_addr", 32'(bram_addr), 32'd0);
`ifdef LOGIC_ANALYZER_READOUT_INDEX_EN
    chk("e_rst_index", 32'(m_index), 32'd0);
`endif
    flush_sb();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      chk("e_idle_valid", 32'(m_valid), 32'd0);
      chk("e_idle_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
    end

    // Simultaneous read and abort edges in idle: abort wins.
    request_read = 1'b1;
    request_abort = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chk("f_both_busy", 32'(busy), 32'd0);
      chk("f_both_en", 32'(bram_en), 32'd0);
      @(posedge clk); #1;
    end
    request_read = 1'b0;
    request_abort = 1'b0;
    @(posedge clk); #1;

    // request_read held high across a whole readout yields exactly one readout.
    push_run(3);
    base_ptr = 3'd3;
    request_read = 1'b1;
    wait_done("g");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("g_no_rerun_valid", 32'(m_valid), 32'd0);
      chk("g_no_rerun_busy", 32'(busy), 32'd0);
    end
    request_read = 1'b0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
